// File: rtl/alu_pkg.sv
// Shared types for the ALU output stage: opcode encoding and the queued result entry.
package alu_pkg;

   localparam int ALU_DATA_W = 64;
   localparam int ALU_OP_W   = 3;

   typedef enum logic [ALU_OP_W-1:0] {
      ADDC = 3'd0,
      SUB  = 3'd1,
      MUL  = 3'd2,
      DIV  = 3'd3,
      MOD  = 3'd4,
      AND  = 3'd5,
      OR   = 3'd6,
      ADD  = 3'd7
   } alu_op_e;

   typedef struct packed {
      logic [ALU_DATA_W-1:0] result;
      alu_op_e               op;
      logic                  zero;
      logic                  div0;
      logic                  hi_nz;
   } alu_rslt_t;

   function automatic logic is_div_class(alu_op_e op);
      return (op == DIV) || (op == MOD);
   endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag derivation for one ALU result before it enters the queue.
module alu_flag_gen
   import alu_pkg::*;
(
   input  logic [ALU_DATA_W-1:0] result_i,
   input  logic [ALU_OP_W-1:0]   opcode_i,
   input  logic                  b_zero_i,
   output alu_rslt_t             rslt_o
);

   alu_op_e               op;
   logic                  div0;
   logic [ALU_DATA_W-1:0] result_fix;

   assign op   = alu_op_e'(opcode_i);
   assign div0 = is_div_class(op) & b_zero_i;

   // A divide by zero leaves the ALU output undefined; force a known pattern instead.
   assign result_fix = div0 ? '1 : result_i;

   always_comb begin
      rslt_o        = '0;
      rslt_o.result = result_fix;
      rslt_o.op     = op;
      rslt_o.zero   = (result_fix == '0);
      rslt_o.div0   = div0;
      rslt_o.hi_nz  = |result_fix[ALU_DATA_W-1:32];
   end

endmodule

// File: rtl/alu_result_queue.sv
// Flag-tagged result FIFO between the combinational ALU and a stallable consumer.
// Optional saturating divide-by-zero counter enabled by ALU_RSLT_STATS_EN.
module alu_result_queue
   import alu_pkg::*;
#(
   parameter int DATA_W = ALU_DATA_W,
   parameter int OP_W   = ALU_OP_W,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        in_result,
   input  logic [OP_W-1:0]          in_opcode,
   input  logic                     in_b_zero,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_result,
   output logic [OP_W-1:0]          out_opcode,
   output logic                     out_zero,
   output logic                     out_div0,
   output logic                     out_hi_nz,
   output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RSLT_STATS_EN
  ,output logic [15:0]              stat_div0_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   alu_rslt_t         mem_q [DEPTH];
   logic [AW-1:0]     wr_q, wr_d;
   logic [AW-1:0]     rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   alu_rslt_t         entry;
   alu_rslt_t         head;
   logic              push;
   logic              pop;

   alu_flag_gen u_flag_gen (
      .result_i (in_result),
      .opcode_i (in_opcode),
      .b_zero_i (in_b_zero),
      .rslt_o   (entry)
   );

   // Ready and valid come only from the registered count, so no in->out path exists.
   assign in_ready  = (cnt_q != CW'(DEPTH));
   assign out_valid = (cnt_q != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) mem_q[wr_q] <= entry;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head       = mem_q[rd_q];
   assign out_result = head.result;
   assign out_opcode = head.op;
   assign out_zero   = head.zero;
   assign out_div0   = head.div0;
   assign out_hi_nz  = head.hi_nz;
   assign count      = cnt_q;

`ifdef ALU_RSLT_STATS_EN
   logic [15:0] div0_cnt_q, div0_cnt_d;

   always_comb begin
      div0_cnt_d = div0_cnt_q;
      if (push && entry.div0 && (div0_cnt_q != 16'hFFFF)) div0_cnt_d = div0_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) div0_cnt_q <= '0;
      else        div0_cnt_q <= div0_cnt_d;
   end

   assign stat_div0_cnt = div0_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Scoreboard bench for alu_result_queue: expected entries queued on accepted push, compared at the head.
module tb_alu_result_queue;

   typedef struct packed {
      logic [63:0] result;
      logic [2:0]  op;
      logic        zero;
      logic        div0;
      logic        hi_nz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_result = '0;
   logic [2:0]  in_opcode = '0;
   logic        in_b_zero = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_result;
   logic [2:0]  out_opcode;
   logic        out_zero;
   logic        out_div0;
   logic        out_hi_nz;
   logic [2:0]  count;
`ifdef ALU_RSLT_STATS_EN
   logic [15:0] stat_div0_cnt;
`endif

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   alu_result_queue dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_opcode  (in_opcode),
      .in_b_zero  (in_b_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_opcode (out_opcode),
      .out_zero   (out_zero),
      .out_div0   (out_div0),
      .out_hi_nz  (out_hi_nz),
      .count      (count)
`ifdef ALU_RSLT_STATS_EN
     ,.stat_div0_cnt (stat_div0_cnt)
`endif
   );

   function automatic exp_t model(input logic [63:0] res, input logic [2:0] op, input logic bz);
      exp_t e;
      e.op    = op;
      e.div0  = bz && (op == 3'b011 || op == 3'b100);
      e.result = e.div0 ? 64'hFFFF_FFFF_FFFF_FFFF : res;
      e.zero  = (e.result == 64'd0);
      e.hi_nz = (e.result[63:32] != 32'd0);
      return e;
   endfunction

   // Drives one cycle from a negedge and updates the scoreboard with the handshake outcome.
   task automatic tick(input logic iv, input logic [63:0] res, input logic [2:0] op,
                       input logic bz, input logic ordy);
      logic do_push, do_pop;
      in_valid = iv; in_result = res; in_opcode = op; in_b_zero = bz; out_ready = ordy;
      do_pop  = ordy && (sb.size() != 0);
      do_push = iv && (sb.size() != 4);
      if (!rst_n) sb.delete();
      else begin
         if (do_pop) void'(sb.pop_front());
         if (do_push) sb.push_back(model(res, op, bz));
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      tick(1'b0, 64'd0, 3'd0, 1'b0, 1'b0);
      tick(1'b0, 64'd0, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (out_result !== 64'd0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
      checks++; if ({out_opcode, out_zero, out_div0, out_hi_nz} !== 6'd0) begin
         failures++; $display("FAIL reset_flags got=%b exp=0", {out_opcode, out_zero, out_div0, out_hi_nz}); end
   endtask

   task automatic test_single;
      tick(1'b1, 64'h0000_0001_0000_0000, 3'd7, 1'b0, 1'b1);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      checks++; if (out_result !== 64'h0000_0001_0000_0000) begin failures++; $display("FAIL single_result got=%h exp=0000000100000000", out_result); end
      checks++; if ({out_hi_nz, out_zero, out_div0} !== 3'b100) begin failures++; $display("FAIL single_flags got=%b exp=100", {out_hi_nz, out_zero, out_div0}); end
      checks++; if (out_opcode !== 3'd7) begin failures++; $display("FAIL single_opcode got=%0d exp=7", out_opcode); end
      tick(1'b0, 64'd0, 3'd0, 1'b0, 1'b1);
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
         failures++; $display("FAIL single_drain count=%0d valid=%b exp count=0 valid=0", count, out_valid); end
   endtask

   task automatic test_fill_drain;
      for (int v = 1; v <= 4; v++) begin
         tick(1'b1, 64'(v), 3'd7, 1'b0, 1'b0);
         checks++; if (count !== 3'(v)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", count, v); end
      end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
      tick(1'b1, 64'd5, 3'd7, 1'b0, 1'b0);
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL fifth_rejected count got=%0d exp=4", count); end
      for (int v = 1; v <= 4; v++) begin
         checks++; if (out_result !== 64'(v) || sb.size() == 0 || out_result !== sb[0].result) begin
            failures++; $display("FAIL drain_order got=%h exp=%h", out_result, 64'(v)); end
         tick(1'b0, 64'd0, 3'd0, 1'b0, 1'b1);
      end
      checks++; if (count !== 3'd0 || sb.size() != 0) begin failures++; $display("FAIL drain_empty count got=%0d exp=0", count); end
   endtask

   task automatic test_back_to_back;
      for (int v = 0; v < 4; v++) tick(1'b1, 64'h10 + 64'(v), 3'(v), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         checks++; if (count !== 3'(sb.size()) || in_ready !== (sb.size() != 4)) begin
            failures++; $display("FAIL b2b_count got=%0d/%b exp=%0d/%b", count, in_ready, sb.size(), sb.size() != 4); end
         checks++; if (sb.size() == 0 || {out_result, out_opcode, out_zero, out_div0, out_hi_nz} !== sb[0]) begin
            failures++; $display("FAIL b2b_head got=%h exp=%h", out_result, (sb.size() != 0) ? sb[0].result : 64'd0); end
         tick(1'b1, {$urandom, $urandom}, 3'(i), 1'b0, 1'b1);
      end
      while (sb.size() != 0) begin
         checks++; if ({out_result, out_opcode, out_zero, out_div0, out_hi_nz} !== sb[0]) begin
            failures++; $display("FAIL b2b_drain got=%h exp=%h", out_result, sb[0].result); end
         tick(1'b0, 64'd0, 3'd0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_div0;
`ifdef ALU_RSLT_STATS_EN
      logic [15:0] cnt0;
      cnt0 = stat_div0_cnt;
`endif
      tick(1'b1, 64'bx, 3'b011, 1'b1, 1'b0);
      tick(1'b1, 64'd0, 3'b100, 1'b1, 1'b0);
      tick(1'b1, 64'd0, 3'b011, 1'b0, 1'b0);
      tick(1'b1, 64'd0, 3'b010, 1'b1, 1'b0);
      in_valid = 1'b0;
      checks++; if (out_result !== 64'hFFFF_FFFF_FFFF_FFFF || out_div0 !== 1'b1 || out_zero !== 1'b0) begin
         failures++; $display("FAIL div0_head result=%h div0=%b zero=%b exp ffffffffffffffff 1 0", out_result, out_div0, out_zero); end
`ifdef ALU_RSLT_STATS_EN
      checks++; if (stat_div0_cnt !== cnt0 + 16'd2) begin
         failures++; $display("FAIL div0_stat got=%0d exp=%0d", stat_div0_cnt, cnt0 + 16'd2); end
`endif
      while (sb.size() != 0) begin
         checks++; if ({out_result, out_opcode, out_zero, out_div0, out_hi_nz} !== sb[0]) begin
            failures++; $display("FAIL div0_entry got=%h/%b exp=%h/%b", out_result, {out_zero, out_div0, out_hi_nz},
                                 sb[0].result, {sb[0].zero, sb[0].div0, sb[0].hi_nz}); end
         tick(1'b0, 64'd0, 3'd0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_reset_mid;
      for (int v = 1; v <= 3; v++) tick(1'b1, 64'hA0 + 64'(v), 3'd0, 1'b0, 1'b0);
      checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
      rst_n = 1'b0;
      tick(1'b1, 64'h55, 3'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0 || out_result !== 64'd0) begin
         failures++; $display("FAIL mid_reset count=%0d valid=%b result=%h exp 0 0 0", count, out_valid, out_result); end
      tick(1'b1, 64'd0, 3'd7, 1'b0, 1'b0);
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_div0 !== 1'b0 || out_hi_nz !== 1'b0) begin
         failures++; $display("FAIL mid_zero_push valid=%b zero=%b div0=%b hi=%b exp 1 1 0 0", out_valid, out_zero, out_div0, out_hi_nz); end
      tick(1'b0, 64'd0, 3'd0, 1'b0, 1'b1);
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_single;
      test_fill_drain;
      test_back_to_back;
      test_div0;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
